fc_mac_engine: RTL

//  Fully-connected layer stage directly downstream of the flatten buffer. On a start pulse it

---
 rtl/npu_fc_pkg.sv | 16 +
 rtl/fc_mac_pipe.sv | 41 ++++
 rtl/fc_mac_engine.sv | 126 ++++++++++++
 3 files changed

// File: rtl/npu_fc_pkg.sv
// Shared widths, scalar types and FSM encoding for the fully-connected MAC engine.
package npu_fc_pkg;

    localparam int N_IN     = 225;
    localparam int N_OUT    = 10;
    localparam int DATA_W   = 22;
    localparam int WEIGHT_W = 8;
    localparam int ACC_W    = DATA_W + WEIGHT_W + $clog2(N_IN);

    typedef logic signed [DATA_W-1:0]   data_t;
    typedef logic signed [WEIGHT_W-1:0] weight_t;
    typedef logic signed [ACC_W-1:0]    acc_t;

    typedef enum logic [1:0] {IDLE, MAC, DRAIN, EMIT} fc_state_e;

endpackage

// File: rtl/fc_mac_pipe.sv
// Two-stage multiply-accumulate: registered full-width product, then sign-extended accumulate.
// The valid shift register tracks which stage holds a live weight so idle cycles add nothing.
module fc_mac_pipe #(
    parameter int DATA_W   = 22,
    parameter int WEIGHT_W = 8,
    parameter int ACC_W    = 38
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       en,
    input  logic signed [DATA_W-1:0]   feature,
    input  logic signed [WEIGHT_W-1:0] weight,
    output logic signed [ACC_W-1:0]    acc
);
    import npu_fc_pkg::*;

    localparam int PROD_W = DATA_W + WEIGHT_W;

    logic [1:0]               vld_pipe;
    logic signed [PROD_W-1:0] prod;
    logic signed [PROD_W-1:0] feat_ext;
    logic signed [PROD_W-1:0] wt_ext;

    assign feat_ext = PROD_W'(feature);
    assign wt_ext   = PROD_W'(weight);

    // en marks the address cycle; the weight lands one cycle later, the sum one after that.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            vld_pipe <= '0;
            prod     <= '0;
            acc      <= '0;
        end else begin
            vld_pipe <= {vld_pipe[0], en};
            if (vld_pipe[0]) prod <= feat_ext * wt_ext;
            if (vld_pipe[1]) acc  <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
        end
    end

endmodule

// File: rtl/fc_mac_engine.sv
// Fully-connected layer engine: N_OUT dot products over the flattened vector, one result per handshake.
// Define FC_RELU_EN to clamp negative neuron sums to zero at the result port.
module fc_mac_engine #(
    parameter int N_IN     = npu_fc_pkg::N_IN,
    parameter int N_OUT    = npu_fc_pkg::N_OUT,
    parameter int DATA_W   = npu_fc_pkg::DATA_W,
    parameter int WEIGHT_W = npu_fc_pkg::WEIGHT_W,
    localparam int ACC_W   = DATA_W + WEIGHT_W + $clog2(N_IN),
    localparam int ADDR_W  = $clog2(N_IN * N_OUT),
    localparam int NEUR_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_start,
    input  logic signed [DATA_W-1:0]   i_flattened_data [N_IN],
    output logic [ADDR_W-1:0]          o_weight_addr,
    output logic                       o_weight_re,
    input  logic signed [WEIGHT_W-1:0] i_weight_data,
    output logic signed [ACC_W-1:0]    o_result,
    output logic [NEUR_W-1:0]          o_result_idx,
    output logic                       o_result_valid,
    input  logic                       i_result_ready,
    output logic                       o_busy,
    output logic                       o_done
);
    import npu_fc_pkg::*;

    localparam int                IDX_W    = $clog2(N_IN);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(N_IN - 1);
    localparam logic [NEUR_W-1:0] LAST_N   = NEUR_W'(N_OUT - 1);

    fc_state_e               state;
    logic [IDX_W-1:0]        idx;
    logic [IDX_W-1:0]        idx_d1;
    logic [NEUR_W-1:0]       neuron;
    logic                    drain_cnt;
    logic                    handshake;
    logic                    clear;
    logic signed [ACC_W-1:0] acc;

    assign handshake = (state == EMIT) && i_result_ready;
    assign clear     = ((state == IDLE) && i_start) || (handshake && (neuron != LAST_N));
    assign o_busy    = (state != IDLE);

    fc_mac_pipe #(
        .DATA_W  (DATA_W),
        .WEIGHT_W(WEIGHT_W),
        .ACC_W   (ACC_W)
    ) u_pipe (
        .clk    (clk),
        .rst    (rst),
        .clear  (clear),
        .en     (o_weight_re),
        .feature(i_flattened_data[idx_d1]),
        .weight (i_weight_data),
        .acc    (acc)
    );

    // acc only settles on the last DRAIN edge, so the result is taken straight off the register.
`ifdef FC_RELU_EN
    assign o_result = (o_result_valid && !acc[ACC_W-1]) ? acc : '0;
`else
    assign o_result = o_result_valid ? acc : '0;
`endif
    assign o_result_idx = o_result_valid ? neuron : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            idx_d1         <= '0;
            neuron         <= '0;
            drain_cnt      <= 1'b0;
            o_weight_addr  <= '0;
            o_weight_re    <= 1'b0;
            o_result_valid <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            o_done <= 1'b0;
            idx_d1 <= idx;
            case (state)
                IDLE: if (i_start) begin
                    state         <= MAC;
                    neuron        <= '0;
                    idx           <= '0;
                    o_weight_addr <= '0;
                    o_weight_re   <= 1'b1;
                end
                MAC: begin
                    // Address stays on the last entry so the neuron advance lands on the next base.
                    if (idx == LAST_IDX) begin
                        state       <= DRAIN;
                        o_weight_re <= 1'b0;
                        drain_cnt   <= 1'b0;
                    end else begin
                        idx           <= idx + 1'b1;
                        o_weight_addr <= o_weight_addr + 1'b1;
                    end
                end
                DRAIN: begin
                    if (drain_cnt) begin
                        state          <= EMIT;
                        o_result_valid <= 1'b1;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                EMIT: if (i_result_ready) begin
                    o_result_valid <= 1'b0;
                    if (neuron == LAST_N) begin
                        state  <= IDLE;
                        o_done <= 1'b1;
                    end else begin
                        state         <= MAC;
                        neuron        <= neuron + 1'b1;
                        idx           <= '0;
                        o_weight_addr <= o_weight_addr + 1'b1;
                        o_weight_re   <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
